locked_adder_sched: RTL

LOCKED_ADDER_SCHED -- requirements
Module: locked_adder_sched

---
 rtl/locked_adder_sched.sv | 130 +++++++++++++
 1 files changed

// File: rtl/locked_adder_sched.sv
// Key loader and two-requester scheduler for a logic-locked 16-bit adder.
// Optional build macro LOCKED_ADDER_SCHED_FIXED_PRIO_EN: requester 0 always wins contention.
module locked_adder_sched #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        key_bit_i,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    output logic [31:0] keyinput_o,
    input  logic [1:0]  req_i,
    input  logic [15:0] a0_i,
    input  logic [15:0] b0_i,
    input  logic [15:0] a1_i,
    input  logic [15:0] b1_i,
    output logic [1:0]  gnt_o,
    output logic [15:0] add1_o,
    output logic [15:0] add2_o,
    input  logic [16:0] sum_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [16:0] rsp_data_o,
    output logic [1:0]  state_o
);

    // Handshake: a response transfers on any rising edge where rsp_valid_o && rsp_ready_i;
    // rsp_valid_o never drops and rsp_id_o/rsp_data_o never change until that transfer.
    typedef enum logic [1:0] {KEYLOAD, IDLE, SETTLE, RESP} state_t;

    state_t      state_q, state_d;
    logic [4:0]  key_cnt_q;
    logic [3:0]  settle_q;
    logic        id_q;
    logic        win;
    logic        issue;
    logic        key_last;

    assign issue    = (state_q == IDLE) && (req_i != 2'b00);
    assign key_last = (state_q == KEYLOAD) && key_valid_i && (key_cnt_q == 5'd31);
    assign state_o  = state_q;

`ifdef LOCKED_ADDER_SCHED_FIXED_PRIO_EN
    assign win = ~req_i[0];
`else
    // Pointer holds the last requester served; reset value 1 lets requester 0 win first.
    logic rr_last_q;

    assign win = (req_i == 2'b11) ? ~rr_last_q : req_i[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_last_q <= 1'b1;
        end else if (issue) begin
            rr_last_q <= win;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= KEYLOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            KEYLOAD: if (key_last) state_d = IDLE;
            IDLE:    if (issue) state_d = SETTLE;
            SETTLE:  if (settle_q == 4'd0) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = KEYLOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_cnt_q   <= 5'd0;
            keyinput_o  <= 32'd0;
            key_ready_o <= 1'b0;
            gnt_o       <= 2'b00;
            add1_o      <= 16'd0;
            add2_o      <= 16'd0;
            settle_q    <= 4'd0;
            id_q        <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_data_o  <= 17'd0;
        end else begin
            gnt_o <= 2'b00;
            case (state_q)
                KEYLOAD: begin
                    if (key_valid_i) begin
                        keyinput_o[key_cnt_q] <= key_bit_i;
                        key_cnt_q             <= key_cnt_q + 5'd1;
                    end
                    if (key_last) key_ready_o <= 1'b1;
                end
                IDLE: begin
                    if (issue) begin
                        gnt_o    <= win ? 2'b10 : 2'b01;
                        add1_o   <= win ? a1_i : a0_i;
                        add2_o   <= win ? b1_i : b0_i;
                        id_q     <= win;
                        settle_q <= 4'(SETTLE_CYC);
                    end
                end
                SETTLE: begin
                    // Counter reaching zero marks SETTLE_CYC+1 edges since issue.
                    if (settle_q == 4'd0) begin
                        rsp_data_o  <= sum_i;
                        rsp_id_o    <= id_q;
                        rsp_valid_o <= 1'b1;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) rsp_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
